// File: rtl/fair_rr_response_router.sv
// fair_rr_response_router: in-order index FIFO steering response bursts to the issuing requester (push side: push_i/push_idx_i/full_o/empty_o/outstanding_o; rsp in: rsp_valid_i/rsp_data_i/rsp_last_i/rsp_ready_o; rsp out: rsp_valid_o/rsp_data_o/rsp_last_o/rsp_ready_i; unexpected_o sticky)
module fair_rr_response_router #(
  parameter int unsigned NumOut = 4,
  parameter int unsigned Depth = 8,
  parameter type DataType = logic,
  localparam int unsigned IdxWidth = $clog2(NumOut),
  localparam int unsigned CntWidth = $clog2(Depth + 1),
  localparam int unsigned PtrWidth = Depth > 1 ? $clog2(Depth) : 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                flush_i,
  input  logic                push_i,
  input  logic [IdxWidth-1:0] push_idx_i,
  output logic                full_o,
  output logic                empty_o,
  output logic [CntWidth-1:0] outstanding_o,
  input  logic                rsp_valid_i,
  input  DataType             rsp_data_i,
  input  logic                rsp_last_i,
  output logic                rsp_ready_o,
  output logic [NumOut-1:0]   rsp_valid_o,
  output DataType             rsp_data_o,
  output logic                rsp_last_o,
  input  logic [NumOut-1:0]   rsp_ready_i,
  output logic                unexpected_o
);
  if (NumOut < 2 || Depth < 1) begin : g_bad_params
    $error("fair_rr_response_router: NumOut must be >= 2 and Depth >= 1");
  end
  logic [IdxWidth-1:0] mem [Depth];
  logic [PtrWidth-1:0] wr_ptr, rd_ptr;
  logic [CntWidth-1:0] count;
  logic                out_valid_q, out_last_q;
  logic [IdxWidth-1:0] out_idx_q;
  DataType             out_data_q;
  logic                push_ok, accept, pop, stage_free;
  always_comb begin
    full_o        = count == CntWidth'(Depth);
    empty_o       = count == '0;
    outstanding_o = count;
    stage_free    = !out_valid_q || rsp_ready_i[out_idx_q];
    rsp_ready_o   = !empty_o && stage_free;
    push_ok       = push_i && !full_o;
    accept        = rsp_valid_i && rsp_ready_o;
    pop           = accept && rsp_last_i;
    rsp_valid_o   = out_valid_q ? {{(NumOut-1){1'b0}}, 1'b1} << out_idx_q : '0;
    rsp_data_o    = out_data_q;
    rsp_last_o    = out_last_q;
  end
  always_ff @(posedge clk_i) begin
    if (push_ok && !flush_i) mem[wr_ptr] <= push_idx_i;
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      unexpected_o <= 1'b0;
    end else if (flush_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      out_valid_q  <= 1'b0;
      out_idx_q    <= '0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      unexpected_o <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr == PtrWidth'(Depth - 1) ? '0 : wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr == PtrWidth'(Depth - 1) ? '0 : rd_ptr + 1'b1;
      count <= count + CntWidth'(push_ok) - CntWidth'(pop);
      if (rsp_valid_i && empty_o) unexpected_o <= 1'b1;
      if (accept) begin
        out_valid_q <= 1'b1;
        out_idx_q   <= mem[rd_ptr];
        out_data_q  <= rsp_data_i;
        out_last_q  <= rsp_last_i;
      end else if (out_valid_q && rsp_ready_i[out_idx_q]) begin
        out_valid_q <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fair_rr_response_router.sv
// tb_fair_rr_response_router: randomized and directed checks against a queue-based reference model
module tb_fair_rr_response_router;
  localparam int N = 4;
  localparam int D = 8;
  logic       clk_i = 0, rst_ni = 0, flush_i = 0, push_i = 0;
  logic [1:0] push_idx_i = 0;
  logic       full_o, empty_o, rsp_ready_o, rsp_last_o, unexpected_o;
  logic [3:0] outstanding_o;
  logic       rsp_valid_i = 0, rsp_last_i = 0;
  logic [7:0] rsp_data_i = 0, rsp_data_o;
  logic [N-1:0] rsp_valid_o, rsp_ready_i = 0;
  int total = 0, bad = 0;
  int q[$];
  bit ov, ol, un;
  int oi;
  logic [7:0] od;
  always #5 clk_i = ~clk_i;
  fair_rr_response_router #(.NumOut(N), .Depth(D), .DataType(logic [7:0])) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i), .push_i(push_i), .push_idx_i(push_idx_i),
    .full_o(full_o), .empty_o(empty_o), .outstanding_o(outstanding_o),
    .rsp_valid_i(rsp_valid_i), .rsp_data_i(rsp_data_i), .rsp_last_i(rsp_last_i), .rsp_ready_o(rsp_ready_o),
    .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_last_o(rsp_last_o), .rsp_ready_i(rsp_ready_i),
    .unexpected_o(unexpected_o)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic check_state();
    check("rsp_valid", 32'(rsp_valid_o), ov ? 32'(1) << oi : 32'(0));
    if (ov) begin
      check("rsp_data", 32'(rsp_data_o), 32'(od));
      check("rsp_last", 32'(rsp_last_o), 32'(ol));
    end
    check("outstanding", 32'(outstanding_o), 32'(q.size()));
    check("full", 32'(full_o), 32'(q.size() == D));
    check("empty", 32'(empty_o), 32'(q.size() == 0));
    check("unexpected", 32'(unexpected_o), 32'(un));
  endtask
  task automatic clear_model();
    q.delete();
    ov = 0;
    oi = 0;
    un = 0;
  endtask
  task automatic cyc(input bit p, input int pi, input bit v, input logic [7:0] d, input bit l,
                     input logic [3:0] rdy, input bit fl);
    bit acc, rd;
    int sz;
    push_i = p; push_idx_i = 2'(pi); rsp_valid_i = v; rsp_data_i = d;
    rsp_last_i = l; rsp_ready_i = rdy; flush_i = fl;
    #3;
    sz = q.size();
    rd = sz != 0 && (!ov || rdy[oi]);
    acc = v && rd;
    check("rsp_ready", 32'(rsp_ready_o), 32'(rd));
    @(posedge clk_i);
    if (fl) clear_model();
    else begin
      if (v && sz == 0) un = 1;
      if (acc) begin
        ov = 1; oi = q[0]; od = d; ol = l;
        if (l) void'(q.pop_front());
      end else if (ov && rdy[oi]) ov = 0;
      if (p && sz < D) q.push_back(pi);
    end
    #1;
    check_state();
  endtask
  task automatic do_reset();
    push_i = 0; flush_i = 0; rsp_valid_i = 1; rsp_ready_i = '1;
    #2;
    rst_ni = 0;
    #1;
    check("rst_valid", 32'(rsp_valid_o), 0);
    check("rst_outst", 32'(outstanding_o), 0);
    check("rst_empty", 32'(empty_o), 1);
    check("rst_full", 32'(full_o), 0);
    check("rst_ready", 32'(rsp_ready_o), 0);
    check("rst_unexp", 32'(unexpected_o), 0);
    clear_model();
    rsp_valid_i = 0;
    @(negedge clk_i);
    rst_ni = 1;
    @(posedge clk_i);
    #1;
  endtask
  initial begin
    #12;
    check("init_valid", 32'(rsp_valid_o), 0);
    check("init_empty", 32'(empty_o), 1);
    check("init_full", 32'(full_o), 0);
    check("init_ready", 32'(rsp_ready_o), 0);
    rst_ni = 1;
    clear_model();
    @(posedge clk_i);
    #1;
    cyc(1, 2, 0, 0, 0, 4'b0100, 0);
    cyc(0, 0, 1, 8'hA5, 1, 4'b0100, 0);
    cyc(0, 0, 0, 0, 0, 4'b0100, 0);
    cyc(1, 1, 0, 0, 0, '1, 0);
    cyc(1, 3, 0, 0, 0, '1, 0);
    cyc(1, 0, 0, 0, 0, '1, 0);
    cyc(0, 0, 1, 8'h11, 0, '1, 0);
    cyc(0, 0, 1, 8'h12, 1, '1, 0);
    cyc(0, 0, 1, 8'h21, 1, '1, 0);
    cyc(0, 0, 1, 8'h31, 0, '1, 0);
    cyc(0, 0, 1, 8'h32, 0, '1, 0);
    cyc(0, 0, 1, 8'h33, 1, '1, 0);
    cyc(0, 0, 0, 0, 0, '1, 0);
    cyc(1, 1, 0, 0, 0, '1, 0);
    cyc(0, 0, 1, 8'h40, 0, 4'b1101, 0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 8'h41, 1, 4'b1101, 0);
    cyc(0, 0, 1, 8'h41, 1, 4'b0010, 0);
    cyc(0, 0, 0, 0, 0, 4'b0010, 0);
    for (int i = 0; i < 9; i++) cyc(1, i % 4, 0, 0, 0, '1, 0);
    for (int i = 0; i < 20; i++) cyc(1, (i * 3) % 4, 1, 8'(i), 1, '1, 0);
    for (int i = 0; i < 10; i++) cyc(0, 0, 1, 8'(i + 100), 1, '1, 0);
    cyc(0, 0, 1, 8'hEE, 1, '1, 0);
    cyc(0, 0, 0, 0, 0, '1, 0);
    cyc(0, 0, 0, 0, 0, '1, 1);
    for (int i = 0; i < 3; i++) cyc(1, i + 1, 0, 0, 0, '1, 0);
    cyc(0, 0, 1, 8'h51, 0, '1, 0);
    cyc(0, 0, 1, 8'h52, 0, '1, 1);
    cyc(0, 0, 0, 0, 0, '1, 0);
    for (int i = 0; i < 3; i++) cyc(1, i, 0, 0, 0, '1, 0);
    cyc(0, 0, 1, 8'h61, 0, '1, 0);
    do_reset();
    check_state();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      else cyc($urandom_range(0, 99) < ((i % 200) < 100 ? 80 : 30), int'($urandom_range(0, 3)),
               $urandom_range(0, 99) < 70, 8'($urandom), $urandom_range(0, 99) < 40,
               4'($urandom), $urandom_range(0, 99) == 0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
